// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared core widths and instruction queue entry type
package core_pkg;

    localparam int XLEN   = 32;
    localparam int INST_W = 32;
    localparam logic [XLEN-1:0] PC_STEP = 32'd4;

    typedef struct packed {
        logic [XLEN-1:0]   pc;
        logic [INST_W-1:0] inst;
    } ifq_entry_t;

endpackage

// File: rtl/ifq_ram.sv
// rtl/ifq_ram.sv - instruction queue storage, two write and two async read ports, no data reset
module ifq_ram
    import core_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic       clk,
    input  logic       we0_i,
    input  logic [AW-1:0] waddr0_i,
    input  ifq_entry_t wdata0_i,
    input  logic       we1_i,
    input  logic [AW-1:0] waddr1_i,
    input  ifq_entry_t wdata1_i,
    input  logic [AW-1:0] raddr0_i,
    output ifq_entry_t rdata0_o,
    input  logic [AW-1:0] raddr1_i,
    output ifq_entry_t rdata1_o
);

    ifq_entry_t mem_q [DEPTH];

    // Port 1 is written after port 0 so it wins if the addresses ever alias.
    always_ff @(posedge clk) begin
        if (we0_i) mem_q[waddr0_i] <= wdata0_i;
        if (we1_i) mem_q[waddr1_i] <= wdata1_i;
    end

    assign rdata0_o = mem_q[raddr0_i];
    assign rdata1_o = mem_q[raddr1_i];

endmodule

// File: rtl/ifetch_queue.sv
// rtl/ifetch_queue.sv - dual-issue fetch PC generator and instruction queue
// Define IFETCH_PERF_EN to build the miss/fetch performance counters.
module ifetch_queue
    import core_pkg::*;
#(
    parameter int          DEPTH    = 8,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] pc0,
    output logic [31:0] pc1,
    input  logic        hit0,
    input  logic        hit1,
    input  logic [31:0] inst0,
    input  logic [31:0] inst1,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic [1:0]  deq_cnt,
    output logic [1:0]  out_valid,
    output logic [31:0] out_inst0,
    output logic [31:0] out_inst1,
    output logic [31:0] out_pc0,
    output logic [31:0] out_pc1,
    output logic        miss_stall,
    output logic [31:0] perf_miss_cycles,
    output logic [31:0] perf_fetched
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]   count_q, count_d;

    logic [CW-1:0] free;
    logic [CW-1:0] enq_n;
    logic [CW-1:0] deq_req;
    logic [CW-1:0] pop;
    logic          enq0, enq1;
    ifq_entry_t    wdata0, wdata1, rdata0, rdata1;

    // Free space is judged on the pre-dequeue count; no same-cycle bypass.
    always_comb begin
        free    = DEPTH_C - count_q;
        enq0    = hit0 && (free != '0) && !redirect_valid;
        enq1    = enq0 && hit1 && (free >= CW'(2));
        enq_n   = enq1 ? CW'(2) : (enq0 ? CW'(1) : '0);
        deq_req = (deq_cnt == 2'd3) ? CW'(2) : CW'(deq_cnt);
        pop     = (deq_req > count_q) ? count_q : deq_req;
    end

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        if (redirect_valid) begin
            fetch_pc_d = redirect_pc & ~32'h3;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
        end else begin
            fetch_pc_d = fetch_pc_q + (enq1 ? 32'd8 : (enq0 ? PC_STEP : 32'd0));
            rd_ptr_d   = rd_ptr_q + AW'(pop);
            wr_ptr_d   = wr_ptr_q + AW'(enq_n);
            count_d    = count_q + enq_n - pop;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc_q <= RESET_PC;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
        end
    end

    assign pc0        = fetch_pc_q;
    assign pc1        = fetch_pc_q + PC_STEP;
    assign miss_stall = !hit0 && !redirect_valid;

    assign wdata0 = '{pc: fetch_pc_q, inst: inst0};
    assign wdata1 = '{pc: pc1, inst: inst1};

    ifq_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk      (clk),
        .we0_i    (enq0),
        .waddr0_i (wr_ptr_q),
        .wdata0_i (wdata0),
        .we1_i    (enq1),
        .waddr1_i (wr_ptr_q + AW'(1)),
        .wdata1_i (wdata1),
        .raddr0_i (rd_ptr_q),
        .rdata0_o (rdata0),
        .raddr1_i (rd_ptr_q + AW'(1)),
        .rdata1_o (rdata1)
    );

    // Unwritten RAM slots hold garbage, so outputs are masked by occupancy.
    always_comb begin
        out_valid = {count_q >= CW'(2), count_q != '0};
        out_inst0 = out_valid[0] ? rdata0.inst : '0;
        out_pc0   = out_valid[0] ? rdata0.pc   : '0;
        out_inst1 = out_valid[1] ? rdata1.inst : '0;
        out_pc1   = out_valid[1] ? rdata1.pc   : '0;
    end

`ifdef IFETCH_PERF_EN
    logic [31:0] miss_cnt_q, fetched_q;
    logic [32:0] fetched_sum;

    assign fetched_sum = {1'b0, fetched_q} + 33'(enq_n);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            miss_cnt_q <= '0;
            fetched_q  <= '0;
        end else begin
            if (miss_stall && (miss_cnt_q != 32'hFFFF_FFFF)) miss_cnt_q <= miss_cnt_q + 32'd1;
            fetched_q <= fetched_sum[32] ? 32'hFFFF_FFFF : fetched_sum[31:0];
        end
    end

    assign perf_miss_cycles = miss_cnt_q;
    assign perf_fetched     = fetched_q;
`else
    assign perf_miss_cycles = 32'h0;
    assign perf_fetched     = 32'h0;
`endif

endmodule

// File: tb/tb_ifetch_queue.sv
// tb/tb_ifetch_queue.sv - directed table-driven bench for ifetch_queue
module tb_ifetch_queue;
    import core_pkg::*;

`ifdef IFETCH_PERF_EN
    localparam bit PERF_EN = 1'b1;
`else
    localparam bit PERF_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] pc0, pc1, inst0, inst1, redirect_pc;
    logic        hit0, hit1, redirect_valid, miss_stall;
    logic [1:0]  deq_cnt, out_valid;
    logic [31:0] out_inst0, out_inst1, out_pc0, out_pc1;
    logic [31:0] perf_miss_cycles, perf_fetched;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    ifetch_queue #(.DEPTH(8), .RESET_PC(32'h0)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .pc0              (pc0),
        .pc1              (pc1),
        .hit0             (hit0),
        .hit1             (hit1),
        .inst0            (inst0),
        .inst1            (inst1),
        .redirect_valid   (redirect_valid),
        .redirect_pc      (redirect_pc),
        .deq_cnt          (deq_cnt),
        .out_valid        (out_valid),
        .out_inst0        (out_inst0),
        .out_inst1        (out_inst1),
        .out_pc0          (out_pc0),
        .out_pc1          (out_pc1),
        .miss_stall       (miss_stall),
        .perf_miss_cycles (perf_miss_cycles),
        .perf_fetched     (perf_fetched)
    );

    typedef struct {
        logic        h0, h1, rv;
        logic [31:0] rpc;
        logic [1:0]  deq;
        logic [31:0] e_pc0;
        logic        e_ms;
        logic [1:0]  e_ov;
        logic [31:0] e_opc0, e_opc1;
        logic [31:0] e_miss;
    } vec_t;

    vec_t vq[$];

    function automatic logic [31:0] inst_of(input logic [31:0] p);
        return {p[15:0] ^ 16'hC0DE, ~p[15:0]};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic add(input logic h0, h1, rv, input logic [31:0] rpc, input logic [1:0] deq,
                       input logic [31:0] e_pc0, input logic e_ms, input logic [1:0] e_ov,
                       input logic [31:0] e_opc0, e_opc1, e_miss);
        vec_t v;
        v = '{h0, h1, rv, rpc, deq, e_pc0, e_ms, e_ov, e_opc0, e_opc1, e_miss};
        vq.push_back(v);
    endtask

    task automatic drive(input logic h0, h1, rv, input logic [31:0] rpc,
                         input logic [1:0] deq, input logic [31:0] cache_pc);
        hit0 = h0; hit1 = h1; redirect_valid = rv; redirect_pc = rpc; deq_cnt = deq;
        inst0 = inst_of(cache_pc);
        inst1 = inst_of(cache_pc + 32'd4);
    endtask

    initial begin
        logic [31:0] head;
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 2'd0, 32'h0);

        //   h0 h1 rv rpc       deq pc0     ms ov opc0    opc1    miss
        add(1, 1, 0, 32'h0,    0, 32'h000, 0, 0, 32'h0,   32'h0,   0);
        add(1, 1, 0, 32'h0,    0, 32'h008, 0, 3, 32'h0,   32'h4,   0);
        add(1, 1, 0, 32'h0,    0, 32'h010, 0, 3, 32'h0,   32'h4,   0);
        add(1, 1, 0, 32'h0,    0, 32'h018, 0, 3, 32'h0,   32'h4,   0);
        add(1, 1, 0, 32'h0,    0, 32'h020, 0, 3, 32'h0,   32'h4,   0);
        add(1, 1, 0, 32'h0,    0, 32'h020, 0, 3, 32'h0,   32'h4,   0);
        add(0, 0, 0, 32'h0,    2, 32'h020, 1, 3, 32'h0,   32'h4,   0);
        add(0, 0, 0, 32'h0,    0, 32'h020, 1, 3, 32'h8,   32'hC,   1);
        add(0, 0, 0, 32'h0,    0, 32'h020, 1, 3, 32'h8,   32'hC,   2);
        add(0, 0, 0, 32'h0,    2, 32'h020, 1, 3, 32'h8,   32'hC,   3);
        add(0, 0, 0, 32'h0,    3, 32'h020, 1, 3, 32'h10,  32'h14,  4);
        add(0, 0, 0, 32'h0,    2, 32'h020, 1, 3, 32'h18,  32'h1C,  5);
        add(0, 0, 0, 32'h0,    0, 32'h020, 1, 0, 32'h0,   32'h0,   6);
        add(0, 1, 1, 32'h100,  0, 32'h020, 0, 0, 32'h0,   32'h0,   7);
        add(1, 0, 0, 32'h0,    0, 32'h100, 0, 0, 32'h0,   32'h0,   7);
        add(0, 0, 0, 32'h0,    0, 32'h104, 1, 1, 32'h100, 32'h0,   7);
        add(0, 0, 0, 32'h0,    2, 32'h104, 1, 1, 32'h100, 32'h0,   8);
        add(0, 0, 0, 32'h0,    0, 32'h104, 1, 0, 32'h0,   32'h0,   9);
        add(1, 1, 0, 32'h0,    0, 32'h104, 0, 0, 32'h0,   32'h0,   10);
        add(1, 1, 0, 32'h0,    0, 32'h10C, 0, 3, 32'h104, 32'h108, 10);
        add(1, 1, 0, 32'h0,    0, 32'h114, 0, 3, 32'h104, 32'h108, 10);
        add(1, 0, 0, 32'h0,    0, 32'h11C, 0, 3, 32'h104, 32'h108, 10);
        add(1, 1, 0, 32'h0,    2, 32'h120, 0, 3, 32'h104, 32'h108, 10);
        add(0, 0, 0, 32'h0,    0, 32'h124, 1, 3, 32'h10C, 32'h110, 10);
        add(0, 0, 0, 32'h0,    1, 32'h124, 1, 3, 32'h10C, 32'h110, 11);
        add(1, 1, 1, 32'h2003, 2, 32'h124, 0, 3, 32'h110, 32'h114, 12);
        add(0, 0, 0, 32'h0,    0, 32'h2000, 1, 0, 32'h0,  32'h0,   12);

        #3;
        check("reset_pc0", pc0, 32'h0);
        check("reset_out_valid", 32'(out_valid), 32'h0);
        check("reset_out_inst0", out_inst0, 32'h0);
        check("reset_perf_miss", perf_miss_cycles, 32'h0);
        check("reset_perf_fetched", perf_fetched, 32'h0);

        @(posedge clk); #1;
        rst_n = 1'b1;
        foreach (vq[i]) begin
            vec_t v;
            v = vq[i];
            drive(v.h0, v.h1, v.rv, v.rpc, v.deq, v.e_pc0);
            @(negedge clk);
            check($sformatf("v%0d_pc0", i), pc0, v.e_pc0);
            check($sformatf("v%0d_pc1", i), pc1, v.e_pc0 + 32'd4);
            check($sformatf("v%0d_miss_stall", i), 32'(miss_stall), 32'(v.e_ms));
            check($sformatf("v%0d_out_valid", i), 32'(out_valid), 32'(v.e_ov));
            check($sformatf("v%0d_out_pc0", i), out_pc0, v.e_opc0);
            check($sformatf("v%0d_out_pc1", i), out_pc1, v.e_opc1);
            check($sformatf("v%0d_out_inst0", i), out_inst0, v.e_ov[0] ? inst_of(v.e_opc0) : 32'h0);
            check($sformatf("v%0d_out_inst1", i), out_inst1, v.e_ov[1] ? inst_of(v.e_opc1) : 32'h0);
            check($sformatf("v%0d_perf_miss", i), perf_miss_cycles, PERF_EN ? v.e_miss : 32'h0);
            @(posedge clk); #1;
        end

        // 24 enqueues from a flushed queue: pointers wrap three times.
        for (int k = 0; k < 12; k++) begin
            drive(1'b1, 1'b1, 1'b0, 32'h0, 2'd2, 32'h2000 + 32'(8 * k));
            @(negedge clk);
            check($sformatf("wrap%0d_pc0", k), pc0, 32'h2000 + 32'(8 * k));
            if (k > 0) begin
                head = 32'h2000 + 32'(8 * (k - 1));
                check($sformatf("wrap%0d_out_valid", k), 32'(out_valid), 32'd3);
                check($sformatf("wrap%0d_out_pc0", k), out_pc0, head);
                check($sformatf("wrap%0d_out_pc1", k), out_pc1, head + 32'd4);
                check($sformatf("wrap%0d_out_inst0", k), out_inst0, inst_of(head));
                check($sformatf("wrap%0d_out_inst1", k), out_inst1, inst_of(head + 32'd4));
            end else begin
                check("wrap0_out_valid", 32'(out_valid), 32'd0);
            end
            @(posedge clk); #1;
        end
        check("final_perf_fetched", perf_fetched, PERF_EN ? 32'd41 : 32'h0);
        check("final_perf_miss", perf_miss_cycles, PERF_EN ? 32'd13 : 32'h0);

        // Reset asserted mid-run with fetch in flight must clear state at once.
        #2 rst_n = 1'b0;
        #1;
        check("midrst_pc0", pc0, 32'h0);
        check("midrst_out_valid", 32'(out_valid), 32'h0);
        check("midrst_out_pc0", out_pc0, 32'h0);
        check("midrst_perf_fetched", perf_fetched, 32'h0);
        check("midrst_perf_miss", perf_miss_cycles, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);
        check("postrst_pc0", pc0, 32'h0);
        check("postrst_out_valid", 32'(out_valid), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
